// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: takes 4-bit opcodes from fetch and sequences
// ALU, memory, write-back and PC update through FETCH/DECODE/EXEC/MEM/WB.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [3:0]       opcode,
  output logic             instr_ready,
  output logic             ir_load,
  output logic [12:0]      dec_onehot,
  output logic             alu_en,
  output logic [2:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             illegal,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_JUMP  = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd12;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [12:0]      dec_q, dec_c;
  logic [TO_W-1:0]  to_q;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q, timeout_q;

  logic ready_c, alu_en_c, mem_req_c, mem_we_c, reg_we_c;
  logic pc_inc_c, pc_load_c, halted_c, to_hit;
  logic is_alu, is_illegal;
  logic [3:0] op_m1;

  assign is_alu     = (op_q >= 4'd1) && (op_q <= 4'd8);
  assign is_illegal = (op_q > OP_HALT);
  assign op_m1      = op_q - 4'd1;
  assign dec_c      = is_illegal ? 13'd0 : (13'd1 << op_q);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    alu_en_c  = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    pc_inc_c  = 1'b0;
    pc_load_c = 1'b0;
    halted_c  = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ready_c = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_illegal)          state_d = S_ERR;
        else if (op_q == OP_HALT) state_d = S_HALT;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_NOP) begin
          pc_inc_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_alu) begin
          alu_en_c = 1'b1;
          state_d  = S_WB;
        end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
          state_d = S_MEM;
        end else if (op_q == OP_JUMP) begin
          pc_load_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_ERR;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (op_q == OP_STORE);
        // An ack in the last allowed cycle is checked first, so it wins.
        if (mem_ack) begin
          if (op_q == OP_STORE) begin
            pc_inc_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_inc_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  halted_c = 1'b1;
      S_ERR:   ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 4'd0;
      dec_q     <= 13'd0;
      to_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) op_q <= opcode;
      if (state_q == S_DECODE) begin
        dec_q <= dec_c;
        if (is_illegal) illegal_q <= 1'b1;
      end
      if (state_q == S_EXEC)     to_q <= '0;
      else if (state_q == S_MEM) to_q <= to_q + TO_W'(1);
      if (pc_inc_c || pc_load_c) cnt_q <= cnt_q + CNT_W'(1);
      if (to_hit) timeout_q <= 1'b1;
    end
  end

  // Outputs are forced low for the whole time rst is high, including the
  // first reset cycle when the state register still holds the old state.
  assign instr_ready = ready_c & ~rst;
  assign ir_load     = instr_valid & instr_ready;
  assign dec_onehot  = rst ? 13'd0 : dec_q;
  assign alu_en      = alu_en_c & ~rst;
  assign alu_op      = alu_en ? op_m1[2:0] : 3'd0;
  assign mem_req     = mem_req_c & ~rst;
  assign mem_we      = mem_we_c & ~rst;
  assign reg_we      = reg_we_c & ~rst;
  assign pc_inc      = pc_inc_c & ~rst;
  assign pc_load     = pc_load_c & ~rst;
  assign instr_count = rst ? '0 : cnt_q;
  assign halted      = halted_c & ~rst;
  assign illegal     = illegal_q & ~rst;
  assign timeout     = timeout_q & ~rst;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (built with CNT_W=4
// so the retired-instruction counter wrap is reachable quickly).
module tb_control_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic [3:0]       opcode = 4'd0;
  logic             mem_ack = 1'b0;
  logic             instr_ready, ir_load, alu_en, mem_req, mem_we;
  logic             reg_we, pc_inc, pc_load, halted, illegal, timeout;
  logic [12:0]      dec_onehot;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.MEM_TIMEOUT(16), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .ir_load(ir_load), .dec_onehot(dec_onehot),
    .alu_en(alu_en), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .instr_count(instr_count), .halted(halted), .illegal(illegal),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; opcode = 4'd0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  // Presents one opcode in FETCH and steps into DECODE.
  task automatic issue(input logic [3:0] op);
    instr_valid = 1'b1; opcode = op;
    #1;
    checks++;
    if (ir_load !== 1'b1) begin
      errors++; $display("FAIL ir_load_op%0d got %0b exp 1", op, ir_load);
    end
    cyc();
    instr_valid = 1'b0;
    #1;
  endtask

  // Runs a LOAD/STORE; acks in MEM cycle ack_at (0 = never). Returns MEM cycles seen.
  task automatic mem_op(input logic [3:0] op, input int ack_at, output int n);
    int guard;
    issue(op);
    cyc();
    cyc();
    n = 0; guard = 0;
    while (mem_req === 1'b1 && guard < 40) begin
      n++; guard++;
      if (n == 1) begin
        checks++;
        if (mem_we !== (op == 4'd10)) begin
          errors++; $display("FAIL mem_we_op%0d got %0b exp %0b", op, mem_we, op == 4'd10);
        end
      end
      if (n == ack_at) begin
        mem_ack = 1'b1;
        #1;
        checks++;
        if (pc_inc !== (op == 4'd10)) begin
          errors++; $display("FAIL ack_pc_inc_op%0d got %0b exp %0b", op, pc_inc, op == 4'd10);
        end
      end
      cyc();
      mem_ack = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    checks++;
    if ({instr_ready, mem_req, halted, illegal, timeout, dec_onehot, instr_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got ready=%0b req=%0b dec=%h cnt=%0d exp all 0",
                         instr_ready, mem_req, dec_onehot, instr_count);
    end
    do_reset();
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", instr_ready);
    end
  endtask

  task automatic test_nop();
    do_reset();
    issue(4'd0);
    checks++;
    if (pc_inc !== 1'b0) begin errors++; $display("FAIL nop_decode_pc_inc got %0b exp 0", pc_inc); end
    cyc();
    checks++;
    if (pc_inc !== 1'b1 || instr_count !== 4'd0) begin
      errors++; $display("FAIL nop_exec got pc_inc=%0b cnt=%0d exp 1/0", pc_inc, instr_count);
    end
    checks++;
    if (dec_onehot !== 13'h0001) begin errors++; $display("FAIL nop_dec got %h exp 0001", dec_onehot); end
    cyc();
    checks++;
    if (pc_inc !== 1'b0 || instr_count !== 4'd1 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL nop_done got pc_inc=%0b cnt=%0d ready=%0b exp 0/1/1",
                         pc_inc, instr_count, instr_ready);
    end
  endtask

  task automatic test_alu();
    do_reset();
    issue(4'd5);
    cyc();
    checks++;
    if (alu_en !== 1'b1 || alu_op !== 3'd4 || reg_we !== 1'b0) begin
      errors++; $display("FAIL alu_exec got en=%0b op=%0d we=%0b exp 1/4/0", alu_en, alu_op, reg_we);
    end
    checks++;
    if (dec_onehot !== 13'h0020) begin errors++; $display("FAIL alu_dec got %h exp 0020", dec_onehot); end
    cyc();
    checks++;
    if (reg_we !== 1'b1 || pc_inc !== 1'b1 || alu_en !== 1'b0) begin
      errors++; $display("FAIL alu_wb got we=%0b inc=%0b en=%0b exp 1/1/0", reg_we, pc_inc, alu_en);
    end
    cyc();
    checks++;
    if (instr_ready !== 1'b1 || instr_count !== 4'd1) begin
      errors++; $display("FAIL alu_done got ready=%0b cnt=%0d exp 1/1", instr_ready, instr_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(4'd8);
    cyc();
    checks++;
    if (alu_op !== 3'd7) begin errors++; $display("FAIL b2b_alu_op got %0d exp 7", alu_op); end
    cyc(); cyc();
    issue(4'd11);
    cyc();
    checks++;
    if (pc_load !== 1'b1 || pc_inc !== 1'b0 || dec_onehot !== 13'h0800) begin
      errors++; $display("FAIL b2b_jump got load=%0b inc=%0b dec=%h exp 1/0/0800",
                         pc_load, pc_inc, dec_onehot);
    end
    cyc();
    checks++;
    if (instr_count !== 4'd2 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_done got cnt=%0d ready=%0b exp 2/1", instr_count, instr_ready);
    end
  endtask

  task automatic test_load_store();
    int n;
    do_reset();
    mem_op(4'd9, 3, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL load_req_cycles got %0d exp 3", n); end
    checks++;
    if (reg_we !== 1'b1 || pc_inc !== 1'b1) begin
      errors++; $display("FAIL load_wb got we=%0b inc=%0b exp 1/1", reg_we, pc_inc);
    end
    cyc();
    mem_op(4'd10, 2, n);
    checks++;
    if (n !== 2 || instr_ready !== 1'b1 || instr_count !== 4'd2) begin
      errors++; $display("FAIL store_done got n=%0d ready=%0b cnt=%0d exp 2/1/2", n, instr_ready, instr_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    mem_op(4'd10, 0, n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 16", n); end
    cyc(); cyc();
    checks++;
    if (timeout !== 1'b1 || instr_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_err got to=%0b ready=%0b req=%0b exp 1/0/0", timeout, instr_ready, mem_req);
    end
    do_reset();
    mem_op(4'd10, 16, n);
    checks++;
    if (n !== 16 || timeout !== 1'b0 || instr_ready !== 1'b1 || instr_count !== 4'd1) begin
      errors++; $display("FAIL late_ack got n=%0d to=%0b ready=%0b cnt=%0d exp 16/0/1/1",
                         n, timeout, instr_ready, instr_count);
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    issue(4'd14);
    cyc();
    checks++;
    if (illegal !== 1'b1 || dec_onehot !== 13'h0000 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL illegal got ill=%0b dec=%h ready=%0b exp 1/0000/0", illegal, dec_onehot, instr_ready);
    end
    do_reset();
    issue(4'd12);
    cyc();
    checks++;
    if (halted !== 1'b1 || dec_onehot !== 13'h1000) begin
      errors++; $display("FAIL halt got halted=%0b dec=%h exp 1/1000", halted, dec_onehot);
    end
    instr_valid = 1'b1; mem_ack = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || ir_load !== 1'b0 || mem_req !== 1'b0 ||
        instr_count !== 4'd0) begin
      errors++; $display("FAIL halt_absorb got halted=%0b ready=%0b load=%0b req=%0b cnt=%0d exp 1/0/0/0/0",
                         halted, instr_ready, ir_load, mem_req, instr_count);
    end
    instr_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    issue(4'd0);
    cyc(); cyc();
    issue(4'd9);
    cyc(); cyc(); cyc();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_mem_req got %0b exp 1", mem_req); end
    rst = 1'b1;
    cyc();
    checks++;
    if ({instr_ready, mem_req, reg_we, pc_inc, pc_load, alu_en, instr_count, dec_onehot} !== '0) begin
      errors++; $display("FAIL rst_mid_mem got ready=%0b req=%0b inc=%0b cnt=%0d dec=%h exp all 0",
                         instr_ready, mem_req, pc_inc, instr_count, dec_onehot);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", instr_ready); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(4'd0);
      cyc(); cyc();
      if (i == 15) begin
        checks++;
        if (instr_count !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", instr_count); end
      end
    end
    checks++;
    if (instr_count !== 4'd1) begin errors++; $display("FAIL wrap_17 got %0d exp 1", instr_count); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_alu();
    test_back_to_back();
    test_load_store();
    test_timeout();
    test_illegal_halt();
    test_reset_mid_mem();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
